pending_write_scoreboard: RTL and testbench
===========================================

Name: pending_write_scoreboard

Overview:
- Producer-side companion to the ID-stage forwarding selector.
- Tracks every register write issued past ID, in order, until it retires at WB.
- Records whether each write's result is already forwardable, e.g. ALU results are, but loads and mfc0 are not until data returns.
- Raises a stall to ID when a source register matches an in-flight write whose data does not exist yet; forwarding alone cannot resolve that case.

Parameters:
- DEPTH, 4, max in-flight tracked writes (power of two, >=2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- flush  input  1  pipeline flush (exception/eret); discards all in-flight entries.
- issue_valid  input  1  ID hands an instruction to EX this cycle.
- issue_wen  input  1  issued instruction writes a GPR.
- issue_waddr  input  5  destination GPR.
- issue_late  input  1  result produced late (load, mfc0); not forwardable until completed.
- issue_ready  output  1  scoreboard can accept an issue; low when full.
- complete_valid  input  1  oldest outstanding late result now available (in-order completion).
- retire_valid  input  1  oldest tracked write leaves WB this cycle.
- r1_addr  input  5  ID source 1.
- r2_addr  input  5  ID source 2.
- stall_id  output  1  ID must hold: r1 or r2 depends on a not-ready write.
- count  output  PTR_W+1  number of valid entries.

Behaviour:
- Reset (resetn=0, async): all entries invalid; head=tail=0; count=0; issue_ready=1; stall_id=0.
- Storage: circular buffer of DEPTH entries; each entry holds valid, addr[4:0], ready.
- Issue: enqueue on issue_valid & issue_wen & issue_ready & issue_waddr!=0, at tail.
  - ready = ~issue_late.
  - tail increments modulo DEPTH, wrapping DEPTH-1 -> 0.
  - Writes to $0 and non-writing instructions are not enqueued.
- issue_ready = (count != DEPTH). It is combinational from registered count only.
- Complete: on complete_valid, the oldest valid entry with ready=0 gets ready=1.
  - If no such entry exists, complete_valid is ignored.
- Retire: on retire_valid & count!=0, invalidate the head entry and increment head.
  - retire_valid with count=0 is ignored.
- Simultaneous issue+retire while full: retire frees a slot, but issue_ready was low, so issue is not accepted in that cycle.
- Simultaneous issue+retire, not full: both occur; count unchanged.
- Simultaneous complete+retire on the same head entry: the entry retires; the complete is consumed by it.
- Flush has priority over issue, complete and retire in the same cycle.
  - All entries invalid; head=tail=0; count=0.
  - Same-cycle issue is dropped.
- Stall is combinational from registered state and r1_addr/r2_addr.
  - For each source, find the youngest valid entry with addr == source.
  - The source is blocked iff that entry exists and has ready=0.
  - Source $0 is never blocked.
  - A ready younger write shadows an older not-ready write: no stall.
  - stall_id = blocked(r1) | blocked(r2).
- Latency: an entry is visible to stall_id the cycle after issue.
  - Completion or retire clears the stall the cycle after it occurs.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- Defined:
  - Adds output stall_cycles[31:0], which increments each cycle stall_id=1 and saturates at 0xFFFFFFFF.
  - Reset value 0; not cleared by flush.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package/header holds:
  - GPR address width constant (5).
  - Zero-register constant.
  - Entry field widths.
- Sub-module sb_youngest_match: combinational.
  - Inputs: entry array, head, source address.
  - Outputs: hit, hit_ready.
  - Instantiated once per source port.

Test Plan:
- Reset mid-operation: 3 entries in flight, pull resetn low asynchronously -> count=0, issue_ready=1, and stall_id=0 immediately without a clock edge.
- Load-use: issue waddr=8, late=1; next cycle r1_addr=8 -> stall_id=1; assert complete_valid -> stall_id=0 next cycle.
- Shadowing: issue late write to $9, then ALU write to $9; r2_addr=9 -> stall_id=0; r2_addr=0 with a pending late write to $0 attempted -> not enqueued, count unchanged.
- Full and wrap-around: 4 issues -> issue_ready=0, count=4.
  - Fifth issue plus retire in the same cycle -> fifth dropped, count=3.
  - Next issue lands in slot 0 after wrap.
- Flush priority: flush with simultaneous issue, complete and retire -> count=0 next cycle, no entries, stall_id=0.
- Stats (SCOREBOARD_STATS_EN): hold a load-use stall for 5 cycles -> stall_cycles=5; flush -> still 5.

Source files
------------

// File: rtl/pending_write_scoreboard_pkg.sv
// Shared constants and entry layout for the pending-write scoreboard.
package pending_write_scoreboard_pkg;

    localparam int GPR_AW = 5;
    localparam logic [GPR_AW-1:0] ZERO_REG = '0;
    localparam int ENTRY_W = GPR_AW + 2;

    typedef struct packed {
        logic              valid;
        logic [GPR_AW-1:0] addr;
        logic              ready;
    } sb_entry_t;

endpackage

// File: rtl/sb_youngest_match.sv
// Finds the youngest valid entry writing a given GPR and reports whether its data exists.
module sb_youngest_match
    import pending_write_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]      head,
    input  logic [GPR_AW-1:0]     src,
    output logic                  hit,
    output logic                  hit_ready
);

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[head + PTR_W'(i)].valid && entries[head + PTR_W'(i)].addr == src) begin
                hit       = 1'b1;
                hit_ready = entries[head + PTR_W'(i)].ready;
            end
        end
    end

endmodule

// File: rtl/pending_write_scoreboard.sv
// In-order tracker of GPR writes past ID; stalls ID on dependence on not-yet-produced data.
// Optional SCOREBOARD_STATS_EN adds a saturating stall_cycles counter.
module pending_write_scoreboard
    import pending_write_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic              issue_wen,
    input  logic [GPR_AW-1:0] issue_waddr,
    input  logic              issue_late,
    output logic              issue_ready,
    input  logic              complete_valid,
    input  logic              retire_valid,
    input  logic [GPR_AW-1:0] r1_addr,
    input  logic [GPR_AW-1:0] r2_addr,
    output logic              stall_id,
`ifdef SCOREBOARD_STATS_EN
    output logic [31:0]       stall_cycles,
`endif
    output logic [PTR_W:0]    count
);

    sb_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  issue_acc, retire_acc, comp_found;
    logic                  r1_hit, r1_rdy, r2_hit, r2_rdy;

    assign issue_ready = (count_q != (PTR_W+1)'(DEPTH));
    assign count       = count_q;

    always_comb begin
        ent_d      = ent_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        comp_found = 1'b0;
        issue_acc  = issue_valid & issue_wen & issue_ready & (issue_waddr != ZERO_REG);
        retire_acc = retire_valid & (count_q != '0);

        // Valid entries are contiguous from head, so scanning from head is age order.
        if (complete_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!comp_found && ent_q[head_q + PTR_W'(i)].valid && !ent_q[head_q + PTR_W'(i)].ready) begin
                    ent_d[head_q + PTR_W'(i)].ready = 1'b1;
                    comp_found = 1'b1;
                end
            end
        end

        if (retire_acc) begin
            ent_d[head_q].valid = 1'b0;
            head_d = head_q + 1'b1;
        end

        if (issue_acc) begin
            ent_d[tail_q].valid = 1'b1;
            ent_d[tail_q].addr  = issue_waddr;
            ent_d[tail_q].ready = ~issue_late;
            tail_d = tail_q + 1'b1;
        end

        count_d = count_q + (PTR_W+1)'(issue_acc) - (PTR_W+1)'(retire_acc);

        if (flush) begin
            ent_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    sb_youngest_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_r1 (
        .entries   (ent_q),
        .head      (head_q),
        .src       (r1_addr),
        .hit       (r1_hit),
        .hit_ready (r1_rdy)
    );

    sb_youngest_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_r2 (
        .entries   (ent_q),
        .head      (head_q),
        .src       (r2_addr),
        .hit       (r2_hit),
        .hit_ready (r2_rdy)
    );

    assign stall_id = ((r1_addr != ZERO_REG) & r1_hit & ~r1_rdy)
                    | ((r2_addr != ZERO_REG) & r2_hit & ~r2_rdy);

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_id && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // Deliberately survives flush; only reset clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stall_cycles_q <= '0;
        else         stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pending_write_scoreboard.sv
// Self-checking bench: directed vector table, corner sequences, and random run against a queue model.
module tb_pending_write_scoreboard;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic resetn, flush, issue_valid, issue_wen, issue_late, complete_valid, retire_valid;
    logic [4:0] issue_waddr, r1_addr, r2_addr;
    logic issue_ready, stall_id;
    logic [PTR_W:0] count;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pending_write_scoreboard #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_wen      (issue_wen),
        .issue_waddr    (issue_waddr),
        .issue_late     (issue_late),
        .issue_ready    (issue_ready),
        .complete_valid (complete_valid),
        .retire_valid   (retire_valid),
        .r1_addr        (r1_addr),
        .r2_addr        (r2_addr),
        .stall_id       (stall_id),
`ifdef SCOREBOARD_STATS_EN
        .stall_cycles   (stall_cycles),
`endif
        .count          (count)
    );

    typedef struct {
        logic       fl, iv, wen;
        logic [4:0] wa;
        logic       late, cv, rv;
        logic [4:0] r1, r2;
        logic [2:0] ecount;
        logic       eready, estall;
    } vec_t;

    typedef struct {
        logic [4:0] a;
        bit         r;
    } ment_t;

    vec_t  tbl[15];
    ment_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic wen, input logic [4:0] wa,
                         input logic late, input logic cv, input logic rv,
                         input logic [4:0] r1, input logic [4:0] r2);
        flush = fl; issue_valid = iv; issue_wen = wen; issue_waddr = wa; issue_late = late;
        complete_valid = cv; retire_valid = rv; r1_addr = r1; r2_addr = r2;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(0, 0, 0, 5'd0, 0, 0, 0, r1, r2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_block(input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == s) return !mq[i].r;
        return 1'b0;
    endfunction

    initial begin
        resetn = 1'b0;
        idle(5'd0, 5'd0);
        #12 resetn = 1'b1;
        tick();

        // Reset state
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ready", 32'(issue_ready), 32'd1);
        chk("reset_stall", 32'(stall_id), 32'd0);

        // Load-use, completion, shadowing, $0 and non-writing issues
        //            fl iv wen wa    late cv rv r1     r2     cnt rdy stl
        tbl[0]  = '{0, 1, 1, 5'd8, 1,   0, 0, 5'd0,  5'd0,  3'd0, 1, 0};
        tbl[1]  = '{0, 0, 0, 5'd0, 0,   0, 0, 5'd8,  5'd0,  3'd1, 1, 1};
        tbl[2]  = '{0, 0, 0, 5'd0, 0,   1, 0, 5'd8,  5'd0,  3'd1, 1, 1};
        tbl[3]  = '{0, 0, 0, 5'd0, 0,   0, 0, 5'd8,  5'd0,  3'd1, 1, 0};
        tbl[4]  = '{0, 0, 0, 5'd0, 0,   0, 1, 5'd8,  5'd0,  3'd1, 1, 0};
        tbl[5]  = '{0, 1, 1, 5'd9, 1,   0, 0, 5'd0,  5'd0,  3'd0, 1, 0};
        tbl[6]  = '{0, 1, 1, 5'd9, 0,   0, 0, 5'd0,  5'd9,  3'd1, 1, 1};
        tbl[7]  = '{0, 0, 0, 5'd0, 0,   0, 0, 5'd0,  5'd9,  3'd2, 1, 0};
        tbl[8]  = '{0, 1, 1, 5'd0, 1,   0, 0, 5'd0,  5'd0,  3'd2, 1, 0};
        tbl[9]  = '{0, 0, 0, 5'd0, 0,   0, 0, 5'd0,  5'd9,  3'd2, 1, 0};
        tbl[10] = '{0, 1, 0, 5'd5, 1,   0, 0, 5'd9,  5'd0,  3'd2, 1, 0};
        tbl[11] = '{0, 0, 0, 5'd0, 0,   0, 0, 5'd5,  5'd0,  3'd2, 1, 0};
        tbl[12] = '{0, 0, 0, 5'd0, 0,   0, 1, 5'd0,  5'd9,  3'd2, 1, 0};
        tbl[13] = '{0, 0, 0, 5'd0, 0,   0, 1, 5'd0,  5'd0,  3'd1, 1, 0};
        tbl[14] = '{0, 0, 0, 5'd0, 0,   0, 0, 5'd9,  5'd0,  3'd0, 1, 0};

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].wen, tbl[i].wa, tbl[i].late,
                  tbl[i].cv, tbl[i].rv, tbl[i].r1, tbl[i].r2);
            #1;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ecount));
            chk($sformatf("vec%0d_ready", i), 32'(issue_ready), 32'(tbl[i].eready));
            chk($sformatf("vec%0d_stall", i), 32'(stall_id), 32'(tbl[i].estall));
            tick();
        end

        // Full and wrap-around
        drive(1, 0, 0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 1, 5'(k), 0, 0, 0, 5'd0, 5'd0);
            tick();
        end
        idle(5'd0, 5'd0);
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(issue_ready), 32'd0);
        drive(0, 1, 1, 5'd5, 1, 0, 1, 5'd0, 5'd0);
        tick();
        idle(5'd5, 5'd0);
        #1;
        chk("fifth_dropped_count", 32'(count), 32'd3);
        chk("fifth_dropped_stall", 32'(stall_id), 32'd0);
        drive(0, 1, 1, 5'd6, 1, 0, 0, 5'd0, 5'd0);
        tick();
        idle(5'd6, 5'd0);
        #1;
        chk("wrap_count", 32'(count), 32'd4);
        chk("wrap_stall", 32'(stall_id), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 5'd0, 0, 0, 1, 5'd6, 5'd0);
            tick();
        end
        idle(5'd6, 5'd0);
        #1;
        chk("wrap_head_count", 32'(count), 32'd1);
        chk("wrap_head_stall", 32'(stall_id), 32'd1);

        // Flush priority over issue, complete and retire
        drive(1, 1, 1, 5'd7, 1, 1, 1, 5'd6, 5'd7);
        tick();
        idle(5'd6, 5'd7);
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_stall", 32'(stall_id), 32'd0);
        chk("flush_ready", 32'(issue_ready), 32'd1);

        // Randomized run against queue model (starts from the empty flushed state)
        mq.delete();
        for (int n = 0; n < 600; n++) begin
            logic fl, iv, wen, late, cv, rv;
            logic [4:0] wa, r1, r2;
            bit acc;
            fl   = ($urandom_range(0, 39) == 0);
            iv   = 1'($urandom_range(0, 1));
            wen  = ($urandom_range(0, 3) != 0);
            wa   = 5'($urandom_range(0, 7));
            late = 1'($urandom_range(0, 1));
            cv   = ($urandom_range(0, 3) == 0);
            rv   = ($urandom_range(0, 2) == 0);
            r1   = 5'($urandom_range(0, 7));
            r2   = 5'($urandom_range(0, 7));
            drive(fl, iv, wen, wa, late, cv, rv, r1, r2);
            #1;
            chk("rand_count", 32'(count), 32'(mq.size()));
            chk("rand_ready", 32'(issue_ready), 32'(mq.size() != DEPTH));
            chk("rand_stall", 32'(stall_id), 32'(m_block(r1) | m_block(r2)));
            if (fl) begin
                mq.delete();
            end else begin
                acc = iv && wen && (mq.size() != DEPTH) && (wa != 5'd0);
                if (cv) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].r) begin
                            mq[i].r = 1'b1;
                            break;
                        end
                    end
                end
                if (rv && mq.size() != 0) void'(mq.pop_front());
                if (acc) mq.push_back('{a: wa, r: !late});
            end
            tick();
        end

        // Asynchronous reset mid-operation
        drive(1, 0, 0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        tick();
        for (int k = 10; k <= 12; k++) begin
            drive(0, 1, 1, 5'(k), 1, 0, 0, 5'd0, 5'd0);
            tick();
        end
        idle(5'd11, 5'd0);
        #1;
        chk("pre_reset_count", 32'(count), 32'd3);
        chk("pre_reset_stall", 32'(stall_id), 32'd1);
        resetn = 1'b0;
        #1;
        chk("async_reset_count", 32'(count), 32'd0);
        chk("async_reset_ready", 32'(issue_ready), 32'd1);
        chk("async_reset_stall", 32'(stall_id), 32'd0);
        #2 resetn = 1'b1;
        tick();

`ifdef SCOREBOARD_STATS_EN
        chk("stats_reset", stall_cycles, 32'd0);
        drive(0, 1, 1, 5'd8, 1, 0, 0, 5'd8, 5'd0);
        tick();
        idle(5'd8, 5'd0);
        repeat (5) tick();
        idle(5'd0, 5'd0);
        #1;
        chk("stats_five", stall_cycles, 32'd5);
        drive(1, 0, 0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        tick();
        idle(5'd8, 5'd0);
        #1;
        chk("stats_after_flush", stall_cycles, 32'd5);
        chk("stats_flush_stall", 32'(stall_id), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
